adder_query_sequencer: RTL and testbench

- Drives operand pairs into the combinational locked 8-bit adder netlist and captures its 9-bit sum after a programmable settle window.
- Compares each captured sum against a locally computed golden sum, then presents the result downstream.
- Keeps saturating query and mismatch counters.
- Wraps the locked adder in key-evaluation and oracle-comparison benches: upstream of the adder's inputA/inputB, downstream of its out.

---
 rtl/adder_query_pkg.sv | 17 +
 rtl/adder_query_sequencer_sat_counter.sv | 22 ++
 rtl/adder_query_sequencer.sv | 121 ++++++++++++
 tb/tb_adder_query_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_query_pkg.sv
// Shared types and defaults for the locked-adder query sequencer.
package adder_query_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int SETTLE_DEF   = 1;
  localparam int CNT_W_DEF    = 16;
  localparam int SETTLE_MIN   = 1;
  localparam int SETTLE_MAX   = 15;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/adder_query_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/adder_query_sequencer.sv
// Drives operand pairs into an external combinational adder, samples its sum
// after a settle window and compares it with a locally computed golden sum.
module adder_query_sequencer
  import adder_query_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH:0]   dut_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum,
  output logic [WIDTH:0]   res_expected,
  output logic             res_match,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] query_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             busy,
  output state_t           state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload stable until that edge.

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

  state_t                  state_next;
  logic                    accept;
  logic                    capture;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [WIDTH:0]          golden;
  logic                    match_now;

  // Full-width sum: the carry lands in bit WIDTH rather than wrapping.
  assign golden    = {1'b0, dut_a} + {1'b0, dut_b};
  assign match_now = (dut_sum == golden);

  assign in_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands stay parked after capture so the adder does not toggle while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_a        <= '0;
      dut_b        <= '0;
      settle_cnt   <= '0;
      res_sum      <= '0;
      res_expected <= '0;
      res_match    <= 1'b0;
    end else begin
      if (accept) begin
        dut_a      <= in_a;
        dut_b      <= in_b;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
      end
      if (capture) begin
        res_sum      <= dut_sum;
        res_expected <= golden;
        res_match    <= match_now;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_query_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture),
    .clr   (clr_cnt),
    .count (query_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (capture && !match_now),
    .clr   (clr_cnt),
    .count (mismatch_cnt)
  );

endmodule

// File: tb/tb_adder_query_sequencer.sv
// Bench for adder_query_sequencer: instance A (SETTLE=1, CNT_W=4) and
// instance B (SETTLE=3, CNT_W=16), each wrapped around a behavioural adder.
module tb_adder_query_sequencer;
  import adder_query_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared and per-instance stimulus ----------------
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic       res_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       wrong_a = 1'b0;

  // instance A outputs
  logic       rdy_a, rv_a, rm_a, busy_a;
  logic [7:0] da_a, db_a;
  logic [8:0] ds_a, rs_a, re_a;
  logic [3:0] qc_a, mc_a;
  state_t     st_a;

  // instance B outputs
  logic        rdy_b, rv_b, rm_b, busy_b;
  logic [7:0]  da_b, db_b;
  logic [8:0]  ds_b, rs_b, re_b;
  logic [15:0] qc_b, mc_b;
  state_t      st_b;

  // Behavioural adders: A can model a wrong key (returns A^B), B is always correct.
  assign ds_a = wrong_a ? {1'b0, da_a ^ db_a} : ({1'b0, da_a} + {1'b0, db_a});
  assign ds_b = {1'b0, da_b} + {1'b0, db_b};

  adder_query_sequencer #(.WIDTH(8), .SETTLE(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(rdy_a), .in_a(in_a), .in_b(in_b),
    .dut_a(da_a), .dut_b(db_a), .dut_sum(ds_a),
    .res_valid(rv_a), .res_ready(res_ready), .res_sum(rs_a),
    .res_expected(re_a), .res_match(rm_a),
    .clr_cnt(clr_cnt), .query_cnt(qc_a), .mismatch_cnt(mc_a),
    .busy(busy_a), .state(st_a)
  );

  adder_query_sequencer #(.WIDTH(8), .SETTLE(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(rdy_b), .in_a(in_a), .in_b(in_b),
    .dut_a(da_b), .dut_b(db_b), .dut_sum(ds_b),
    .res_valid(rv_b), .res_ready(res_ready), .res_sum(rs_b),
    .res_expected(re_b), .res_match(rm_b),
    .clr_cnt(clr_cnt), .query_cnt(qc_b), .mismatch_cnt(mc_b),
    .busy(busy_b), .state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] exp_q_a[$];
  logic [18:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Packs {sum, expected, match} for one query as the adder model will answer it.
  function automatic logic [18:0] mk_exp(input logic [7:0] a, input logic [7:0] b,
                                         input logic wrong);
    logic [8:0] e;
    logic [8:0] s;
    e = {1'b0, a} + {1'b0, b};
    s = wrong ? {1'b0, a ^ b} : e;
    return {s, e, (s == e)};
  endfunction

  // Monitor: pops on every result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv_a && res_ready) begin
        if (exp_q_a.size() == 0) check("unexpected_res_a", 32'(rs_a), 32'h1ff);
        else check("res_a", 32'({rs_a, re_a, rm_a}), 32'(exp_q_a.pop_front()));
      end
      if (rv_b && res_ready) begin
        if (exp_q_b.size() == 0) check("unexpected_res_b", 32'(rs_b), 32'h1ff);
        else check("res_b", 32'({rs_b, re_b, rm_b}), 32'(exp_q_b.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (all run in the posedge+1 phase) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    while (!rdy_a && t < 100) begin tick(); t++; end
    if (t >= 100) check("timeout_ready_a", 32'(rdy_a), 32'd1);
    in_a = a; in_b = b; in_valid_a = 1'b1;
    exp_q_a.push_back(mk_exp(a, b, wrong_a));
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic accept_b(input logic [7:0] a, input logic [7:0] b, input logic push);
    int t = 0;
    while (!rdy_b && t < 100) begin tick(); t++; end
    if (t >= 100) check("timeout_ready_b", 32'(rdy_b), 32'd1);
    in_a = a; in_b = b; in_valid_b = 1'b1;
    if (push) exp_q_b.push_back(mk_exp(a, b, 1'b0));
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int t = 0;
    while (!rdy_a && t < 100) begin tick(); t++; end
    if (t >= 100) check("timeout_idle_a", 32'(rdy_a), 32'd1);
  endtask

  task automatic wait_idle_b();
    int t = 0;
    while (!rdy_b && t < 100) begin tick(); t++; end
    if (t >= 100) check("timeout_idle_b", 32'(rdy_b), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(rdy_a), 32'd1);
    check("rst_res_valid", 32'(rv_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_dut_ab", 32'({da_a, db_a}), 32'd0);
    check("rst_counters", 32'({qc_a, mc_a}), 32'd0);
    check("rst_res_regs", 32'({rs_a, re_a, rm_a}), 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    // Correct adder, carry out: FF + 01 = 100
    wrong_a = 1'b0;
    accept_a(8'hFF, 8'h01);
    check("settle_no_valid", 32'(rv_a), 32'd0);
    check("settle_busy", 32'(busy_a), 32'd1);
    check("settle_in_ready", 32'(rdy_a), 32'd0);
    check("settle_dut_ab", 32'({da_a, db_a}), 32'hFF01);
    tick();
    check("latency_valid", 32'(rv_a), 32'd1);
    check("cnt_after_good", 32'({qc_a, mc_a}), 32'h10);
    wait_idle_a();

    // Wrong key: 0F ^ 01 = 0E vs golden 010
    wrong_a = 1'b1;
    accept_a(8'h0F, 8'h01);
    tick();
    check("cnt_after_bad", 32'({qc_a, mc_a}), 32'h21);
    wait_idle_a();

    // Backpressure in HOLD with the next operands already offered
    wrong_a = 1'b0;
    res_ready = 1'b0;
    accept_a(8'h12, 8'h34);
    tick();
    in_a = 8'h55; in_b = 8'hAA; in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(rv_a), 32'd1);
      check("bp_res_stable", 32'({rs_a, re_a, rm_a}), 32'({9'h046, 9'h046, 1'b1}));
      check("bp_in_ready", 32'(rdy_a), 32'd0);
      check("bp_dut_a", 32'(da_a), 32'h12);
    end
    res_ready = 1'b1;
    tick();
    check("bubble_ready", 32'(rdy_a), 32'd1);
    check("bubble_no_accept", 32'(da_a), 32'h12);
    exp_q_a.push_back(mk_exp(8'h55, 8'hAA, 1'b0));
    tick();
    in_valid_a = 1'b0;
    check("accept_after_bubble", 32'({da_a, db_a}), 32'h55AA);
    wait_idle_a();
    check("cnt_after_bp", 32'({qc_a, mc_a}), 32'h41);

    // Saturation: 20 mismatching queries on a 4-bit counter
    wrong_a = 1'b1;
    for (int i = 1; i <= 20; i++) accept_a(8'(i), 8'hFF);
    wait_idle_a();
    check("sat_counters", 32'({qc_a, mc_a}), 32'hFF);

    // Clear on the capture edge wins; result still delivered
    accept_a(8'h0F, 8'h01);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_counters", 32'({qc_a, mc_a}), 32'h00);
    check("clr_result_valid", 32'(rv_a), 32'd1);
    wait_idle_a();
    accept_a(8'h0F, 8'h01);
    tick();
    check("cnt_after_clr", 32'({qc_a, mc_a}), 32'h11);
    wait_idle_a();

    // SETTLE = 3 latency on instance B
    accept_b(8'h3C, 8'hC4, 1'b1);
    check("b_lat0", 32'(rv_b), 32'd0);
    tick();
    check("b_lat1", 32'(rv_b), 32'd0);
    tick();
    check("b_lat2", 32'(rv_b), 32'd0);
    tick();
    check("b_lat3", 32'(rv_b), 32'd1);
    check("b_query_cnt", 32'(qc_b), 32'd1);
    wait_idle_b();

    // Reset in the middle of SETTLE drops the query
    accept_b(8'h01, 8'h02, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("b_rst_valid", 32'(rv_b), 32'd0);
    check("b_rst_state", 32'(st_b), 32'(ST_IDLE));
    check("b_rst_ready", 32'(rdy_b), 32'd1);
    check("b_rst_cnt", 32'({qc_b, mc_b}), 32'd0);
    check("b_rst_dut_a", 32'(da_b), 32'd0);
    repeat (6) tick();
    check("b_no_late_valid", 32'(rv_b), 32'd0);
    accept_b(8'h10, 8'h20, 1'b1);
    wait_idle_b();
    check("b_cnt_after_rst", 32'(qc_b), 32'd1);

    repeat (3) tick();
    check("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
    check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
